// File: rtl/dac_tx_sequencer.sv
// Pulsed-transmit sequencer: alternates TX-on/TX-off windows, paces a sample
// strobe toward the DAC, pulls I/Q from the source and flags source underflow.
module dac_tx_sequencer #(
  parameter int WIDTH  = 14,
  parameter int CNT_W  = 24,
  parameter int RATE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ena_i,
  input  logic [CNT_W-1:0]  cfg_ton_i,
  input  logic [CNT_W-1:0]  cfg_toff_i,
  input  logic [RATE_W-1:0] cfg_rate_i,
  input  logic              cfg_load_i,
  input  logic              src_valid_i,
  input  logic [WIDTH-1:0]  src_i_i,
  input  logic [WIDTH-1:0]  src_q_i,
  output logic              src_ready_o,
  output logic [WIDTH-1:0]  tx_i_o,
  output logic [WIDTH-1:0]  tx_q_o,
  output logic              tx_strobe_o,
  output logic              tx_ena_o,
  output logic              pulse_start_o,
  output logic              underflow_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TXON  = 2'd1,
    S_TXOFF = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RATE_W-1:0] RATE_ZERO = {RATE_W{1'b0}};
  localparam logic [RATE_W-1:0] RATE_ONE  = {{(RATE_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  DATA_ZERO = {WIDTH{1'b0}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    ton_sh_q, ton_sh_d, toff_sh_q, toff_sh_d;
  logic [RATE_W-1:0]   rate_sh_q, rate_sh_d;
  logic [CNT_W-1:0]    ton_act_q, ton_act_d, toff_act_q, toff_act_d;
  logic [RATE_W-1:0]   rate_act_q, rate_act_d;
  logic [CNT_W-1:0]    win_q, win_d;
  logic [RATE_W-1:0]   rate_cnt_q, rate_cnt_d;
  logic                stop_q, stop_d;
  logic [WIDTH-1:0]    tx_i_q, tx_i_d, tx_q_q, tx_q_d;
  logic                strobe_q, strobe_d;
  logic                ena_q, ena_d;
  logic                pulse_q, pulse_d;
  logic                unf_q, unf_d;

  logic                tick_s, win_end_s, enter_on_s;
  logic [CNT_W-1:0]    ton_last_s, toff_last_s;

  // Next-state computation for the sequencer, counters, config and outputs
  always_comb begin
    ton_last_s  = (ton_act_q  == CNT_ZERO) ? CNT_ZERO : ton_act_q  - CNT_ONE;
    toff_last_s = (toff_act_q == CNT_ZERO) ? CNT_ZERO : toff_act_q - CNT_ONE;
    tick_s      = (state_q != S_IDLE) && (rate_cnt_q == RATE_ZERO);

    if (state_q == S_TXON) begin
      win_end_s = (win_q == ton_last_s);
    end else if (state_q == S_TXOFF) begin
      win_end_s = (win_q == toff_last_s);
    end else begin
      win_end_s = 1'b0;
    end

    case (state_q)
      S_IDLE:  state_d = ena_i ? S_TXON : S_IDLE;
      S_TXON:  state_d = win_end_s ? ((stop_q || !ena_i) ? S_IDLE : S_TXOFF) : S_TXON;
      S_TXOFF: state_d = !ena_i ? S_IDLE : (win_end_s ? S_TXON : S_TXOFF);
      default: state_d = S_IDLE;
    endcase

    enter_on_s = (state_d == S_TXON) && (state_q != S_TXON);

    // A load coinciding with window entry lands straight in the active set
    ton_sh_d   = cfg_load_i ? cfg_ton_i  : ton_sh_q;
    toff_sh_d  = cfg_load_i ? cfg_toff_i : toff_sh_q;
    rate_sh_d  = cfg_load_i ? cfg_rate_i : rate_sh_q;
    ton_act_d  = enter_on_s ? ton_sh_d   : ton_act_q;
    toff_act_d = enter_on_s ? toff_sh_d  : toff_act_q;
    rate_act_d = enter_on_s ? rate_sh_d  : rate_act_q;

    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      win_d = CNT_ZERO;
    end else begin
      win_d = win_q + CNT_ONE;
    end

    if (enter_on_s || (state_d == S_IDLE)) begin
      rate_cnt_d = RATE_ZERO;
    end else if (rate_cnt_q >= rate_act_q) begin
      rate_cnt_d = RATE_ZERO;
    end else begin
      rate_cnt_d = rate_cnt_q + RATE_ONE;
    end

    if (enter_on_s) begin
      stop_d = 1'b0;
    end else if ((state_q == S_TXON) && !ena_i) begin
      stop_d = 1'b1;
    end else begin
      stop_d = stop_q;
    end

    if (state_d == S_IDLE) begin
      strobe_d = 1'b0;
      tx_i_d   = DATA_ZERO;
      tx_q_d   = DATA_ZERO;
    end else if (tick_s) begin
      strobe_d = 1'b1;
      tx_i_d   = ((state_q == S_TXON) && src_valid_i) ? src_i_i : DATA_ZERO;
      tx_q_d   = ((state_q == S_TXON) && src_valid_i) ? src_q_i : DATA_ZERO;
    end else begin
      strobe_d = 1'b0;
      tx_i_d   = tx_i_q;
      tx_q_d   = tx_q_q;
    end

    if ((state_q == S_IDLE) && (state_d == S_TXON)) begin
      unf_d = 1'b0;
    end else if (tick_s && (state_q == S_TXON) && !src_valid_i) begin
      unf_d = 1'b1;
    end else begin
      unf_d = unf_q;
    end

    ena_d   = (state_d != S_IDLE);
    pulse_d = enter_on_s;
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      ton_sh_q   <= CNT_ZERO;
      toff_sh_q  <= CNT_ZERO;
      rate_sh_q  <= RATE_ZERO;
      ton_act_q  <= CNT_ZERO;
      toff_act_q <= CNT_ZERO;
      rate_act_q <= RATE_ZERO;
      win_q      <= CNT_ZERO;
      rate_cnt_q <= RATE_ZERO;
      stop_q     <= 1'b0;
      tx_i_q     <= DATA_ZERO;
      tx_q_q     <= DATA_ZERO;
      strobe_q   <= 1'b0;
      ena_q      <= 1'b0;
      pulse_q    <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ton_sh_q   <= ton_sh_d;
      toff_sh_q  <= toff_sh_d;
      rate_sh_q  <= rate_sh_d;
      ton_act_q  <= ton_act_d;
      toff_act_q <= toff_act_d;
      rate_act_q <= rate_act_d;
      win_q      <= win_d;
      rate_cnt_q <= rate_cnt_d;
      stop_q     <= stop_d;
      tx_i_q     <= tx_i_d;
      tx_q_q     <= tx_q_d;
      strobe_q   <= strobe_d;
      ena_q      <= ena_d;
      pulse_q    <= pulse_d;
      unf_q      <= unf_d;
    end
  end

  assign src_ready_o   = tick_s && (state_q == S_TXON);
  assign tx_i_o        = tx_i_q;
  assign tx_q_o        = tx_q_q;
  assign tx_strobe_o   = strobe_q;
  assign tx_ena_o      = ena_q;
  assign pulse_start_o = pulse_q;
  assign underflow_o   = unf_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_dac_tx_sequencer.sv
// Directed bench for dac_tx_sequencer: windows, strobe pacing, underflow,
// early stop, zero-length windows, coincident config load and async reset.
module tb_dac_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [23:0] cfg_ton = 24'd0;
  logic [23:0] cfg_toff = 24'd0;
  logic [7:0]  cfg_rate = 8'd0;
  logic        cfg_load = 1'b0;
  logic        src_valid = 1'b0;
  logic [13:0] src_val = 14'd1;
  logic [13:0] src_q;
  logic        src_ready;
  logic [13:0] tx_i, tx_q;
  logic        tx_strobe, tx_ena, pulse_start, underflow;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  assign src_q = src_val + 14'd100;

  always #5 clk = ~clk;

  dac_tx_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n), .ena_i(ena),
    .cfg_ton_i(cfg_ton), .cfg_toff_i(cfg_toff), .cfg_rate_i(cfg_rate),
    .cfg_load_i(cfg_load), .src_valid_i(src_valid),
    .src_i_i(src_val), .src_q_i(src_q), .src_ready_o(src_ready),
    .tx_i_o(tx_i), .tx_q_o(tx_q), .tx_strobe_o(tx_strobe),
    .tx_ena_o(tx_ena), .pulse_start_o(pulse_start),
    .underflow_o(underflow), .state_o(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; the source advances when its sample was accepted on that edge
  task automatic step();
    logic fire;
    fire = src_ready && src_valid;
    @(posedge clk);
    @(negedge clk);
    if (fire) src_val = src_val + 14'd1;
  endtask

  initial begin
    int exp_i0 [12] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0, 0};
    int c, w, ei;
    logic [13:0] sv;

    @(negedge clk);
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_tx_ena", tx_ena, 0);
    chk("rst_strobe", tx_strobe, 0);
    chk("rst_tx_i", tx_i, 0);
    chk("rst_unf", underflow, 0);
    rst_n = 1'b1;

    // basic windows: ton=8 toff=4 rate=1
    cfg_ton = 24'd8; cfg_toff = 24'd4; cfg_rate = 8'd1; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("idle_state", state, 0);
    ena = 1'b1; src_valid = 1'b1;
    for (int n = 0; n < 24; n++) begin
      step();
      c = n % 12;
      w = n / 12;
      ei = (exp_i0[c] == 0) ? 0 : exp_i0[c] + 4 * w;
      chk($sformatf("t1_state_%0d", n), state, (c < 8) ? 1 : 2);
      chk($sformatf("t1_pulse_%0d", n), pulse_start, (c == 0) ? 1 : 0);
      chk($sformatf("t1_strobe_%0d", n), tx_strobe, c % 2);
      chk($sformatf("t1_tx_i_%0d", n), tx_i, ei);
      chk($sformatf("t1_tx_ena_%0d", n), tx_ena, 1);
      if (n == 1 || n == 14) chk($sformatf("t1_tx_q_%0d", n), tx_q, ei + 100);
    end
    chk("t1_unf", underflow, 0);

    // underflow on the 2nd tick of window 2
    step();
    chk("t2_c0_state", state, 1);
    chk("t2_c0_pulse", pulse_start, 1);
    step();
    chk("t2_c1_tx_i", tx_i, 9);
    src_valid = 1'b0;
    step();
    chk("t2_c2_ready", src_ready, 1);
    step();
    chk("t2_c3_strobe", tx_strobe, 1);
    chk("t2_c3_tx_i", tx_i, 0);
    chk("t2_c3_unf", underflow, 1);
    src_valid = 1'b1;
    step();
    chk("t2_c4_tx_i", tx_i, 0);
    chk("t2_c4_unf", underflow, 1);
    step();
    chk("t2_c5_tx_i", tx_i, 10);
    for (int k = 0; k < 7; k++) step();
    chk("t2_w3_state", state, 1);
    chk("t2_w3_pulse", pulse_start, 1);
    chk("t2_w3_unf_sticky", underflow, 1);

    // mid-window load of ton=100, then stop during TXON
    cfg_ton = 24'd100; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    step();
    ena = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("t3_c7_state", state, 1);
    step();
    chk("t3_stop_state", state, 0);
    chk("t3_stop_tx_ena", tx_ena, 0);
    chk("t3_stop_strobe", tx_strobe, 0);
    chk("t3_stop_tx_i", tx_i, 0);
    chk("t3_idle_unf", underflow, 1);
    step();
    chk("t3_idle2_state", state, 0);
    ena = 1'b1;
    step();
    chk("t3_k0_state", state, 1);
    chk("t3_k0_pulse", pulse_start, 1);
    chk("t3_k0_unf_clr", underflow, 0);
    for (int k = 0; k < 99; k++) step();
    chk("t3_k99_state", state, 1);
    step();
    chk("t3_k100_state", state, 2);
    ena = 1'b0;
    step();
    chk("t3_off_stop_state", state, 0);

    // zero-length windows, strobe every cycle
    cfg_ton = 24'd0; cfg_toff = 24'd0; cfg_rate = 8'd0; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    ena = 1'b1;
    step();
    sv = src_val;
    chk("t4_c0_state", state, 1);
    chk("t4_c0_pulse", pulse_start, 1);
    chk("t4_c0_strobe", tx_strobe, 0);
    step();
    chk("t4_c1_state", state, 2);
    chk("t4_c1_strobe", tx_strobe, 1);
    chk("t4_c1_tx_i", tx_i, sv);
    chk("t4_c1_pulse", pulse_start, 0);
    step();
    chk("t4_c2_state", state, 1);
    chk("t4_c2_strobe", tx_strobe, 1);
    chk("t4_c2_tx_i", tx_i, 0);
    chk("t4_c2_pulse", pulse_start, 1);
    step();
    chk("t4_c3_state", state, 2);
    chk("t4_c3_strobe", tx_strobe, 1);
    chk("t4_c3_tx_i", tx_i, sv + 14'd1);
    ena = 1'b0;
    step();
    chk("t4_stop_state", state, 0);

    // load coincident with TXON entry: ton=3 used at once
    ena = 1'b1; cfg_load = 1'b1;
    cfg_ton = 24'd3; cfg_toff = 24'd2; cfg_rate = 8'd0;
    step();
    cfg_load = 1'b0;
    chk("t5_c0_state", state, 1);
    step();
    step();
    chk("t5_c2_state", state, 1);
    step();
    chk("t5_c3_state", state, 2);
    step();
    chk("t5_c4_state", state, 2);
    step();
    chk("t5_c5_state", state, 1);
    step();
    chk("t5_c6_strobe", tx_strobe, 1);
    chk("t5_c6_tx_nonzero", (tx_i != 14'd0) ? 1 : 0, 1);

    // asynchronous reset in the middle of TXON
    #2 rst_n = 1'b0;
    #1;
    chk("t6_state", state, 0);
    chk("t6_tx_ena", tx_ena, 0);
    chk("t6_strobe", tx_strobe, 0);
    chk("t6_tx_i", tx_i, 0);
    chk("t6_tx_q", tx_q, 0);
    chk("t6_pulse", pulse_start, 0);
    chk("t6_ready", src_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_post_state", state, 1);
    step();
    chk("t6_cfg_cleared_state", state, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_tx_sequencer.md
Name: dac_tx_sequencer

Overview:
- Pulsed-transmit controller for the radar-mono TX path; sits between the waveform/sample source and the DAC interleave interface.
- Generates repeating TX-on/TX-off windows and a programmable-rate sample strobe.
- Pulls I/Q samples from the upstream source with a ready/valid handshake, forces zero output outside the TX window, and flags source underflow.

Parameters:
- WIDTH, 14, sample width of I and Q.
- CNT_W, 24, width of the on/off window counters.
- RATE_W, 8, width of the strobe divider.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_n_i  in  1  asynchronous reset, asserted low; all state is cleared immediately on assertion.
- ena_i  in  1  run enable.
- cfg_ton_i  in  CNT_W  TX-on window length in clocks.
- cfg_toff_i  in  CNT_W  TX-off window length in clocks.
- cfg_rate_i  in  RATE_W  strobe period minus 1, in clocks.
- cfg_load_i  in  1  single-cycle pulse that latches cfg_* into the shadow registers.
- src_valid_i  in  1  upstream sample available.
- src_i_i  in  WIDTH  upstream I sample.
- src_q_i  in  WIDTH  upstream Q sample.
- src_ready_o  out  1  combinational; the sample is consumed on the edge where src_ready_o and src_valid_i are both high.
- tx_i_o  out  WIDTH  registered I sample to the DAC interface.
- tx_q_o  out  WIDTH  registered Q sample to the DAC interface.
- tx_strobe_o  out  1  registered sample strobe to the DAC interface.
- tx_ena_o  out  1  registered; high in TXON and TXOFF.
- pulse_start_o  out  1  registered one-cycle pulse on the first TXON cycle of each window.
- underflow_o  out  1  sticky underflow flag.
- state_o  out  2  current state: IDLE=0, TXON=1, TXOFF=2.

Behaviour:
- Reset values: tx_i_o=0, tx_q_o=0, tx_strobe_o=0, tx_ena_o=0, pulse_start_o=0, underflow_o=0, state=IDLE; shadow and active config registers all 0; all counters 0.
- Config: cfg_load_i loads the shadow registers in any state. Shadow values are copied to the active registers on every TXON entry; changes therefore take effect on the next window only. An active ton or toff value of 0 is treated as 1.
- IDLE:
  - tx_ena_o=0, outputs held at 0, no strobes.
  - When ena_i=1, go to TXON on the next edge.
  - The IDLE→TXON entry clears underflow_o.
- TXON:
  - The window counter runs for ton cycles, then the state goes to TXOFF.
  - The rate counter resets to 0 on entry and counts 0..rate, wrapping to 0.
  - tick = (rate counter == 0), so the first tick is the first TXON cycle.
  - src_ready_o = tick & (state==TXON).
  - On a tick edge with src_valid_i=1: the next cycle has tx_strobe_o=1 and tx_i_o/tx_q_o = the captured sample (1-clock latency).
  - On a tick edge with src_valid_i=0: the next cycle has tx_strobe_o=1, data=0, and underflow_o set.
  - Data is held between strobes.
- TXOFF:
  - Runs for toff cycles.
  - The strobe continues at the same rate with data forced to 0; src_ready_o=0.
  - At the end of the window: if ena_i=1, go to TXON (pulse_start_o and a fresh config copy); otherwise go to IDLE.
- ena_i deassert:
  - During TXON, the current window completes and the state goes IDLE at its end (no TXOFF).
  - During TXOFF, the state goes IDLE on the next edge.
- Simultaneous cfg_load_i and TXON entry: the new cfg_* values are used for that window, i.e. the load is bypassed into the active registers.
- Wrap-around: counters are compared against the active value minus 1, so there is no overflow beyond CNT_W. rate=0 gives a strobe every cycle.
- Reset mid-window forces all outputs to their reset values immediately. Partial samples are discarded.

Test Plan:
- Reset, load ton=8, toff=4, rate=1, hold ena_i=1 with src_valid_i=1 and an incrementing source from 1 → states cycle TXON×8, TXOFF×4. tx_strobe_o fires every 2 clocks. tx_i_o = 1, 2, 3, 4 in TXON and 0 in TXOFF. pulse_start_o fires every 12 cycles.
- Same config with src_valid_i=0 on the 2nd tick → that strobe carries data 0 and underflow_o=1 until the next IDLE→TXON.
- Load ton=100 mid-window, then deassert ena_i in cycle 3 of TXON → the current window lasts 8 cycles, then the state goes IDLE with no TXOFF. The next enable runs 100-cycle windows.
- ton=0, toff=0, rate=0 → 1-cycle TXON alternating with 1-cycle TXOFF; a strobe every cycle; data only in TXON cycles.
- cfg_load_i coincident with TXON entry → the new ton is used immediately.
- Assert rst_n_i low mid-TXON → all outputs are 0 and state_o=0 in the same cycle, before the next clock edge.
